ptr_gen: RTL and testbench

TU-12 pointer generator for the transmit side of the multiframe path. It builds the four V bytes (V1 to V4) of each 500 µs TU-12 multiframe. It carries pointer offset, positive/negative justification and new-data-flag (NDF) events. It inserts TU AIS on demand. Its V1/V2 encoding is the one the receive-side pointer interpreter decodes, and it sits between the transmit TU-12 mapper and the multiframe byte multiplexer.

---
 rtl/ptr_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_ptr_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ptr_gen.sv
// ptr_gen: TU-12 pointer generator. Builds the V1..V4 bytes of each
// multiframe and carries offset, justification, NDF and TU AIS events.
//
// Multiframe mode, fixed at the V1 slot (commit):
//   mode      | meaning
//   MODE_NORM | normal pointer, or new/restore pointer sent with EN_NDF
//   MODE_AIS  | all four V bytes are 8'hFF
//   MODE_INC  | I bits inverted, stuff byte after V3, offset +1 at V4
//   MODE_DEC  | D bits inverted, V3 carries data, offset -1 at V4
module ptr_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       txsof,
  input  logic       ven,
  input  logic       inc_req,
  input  logic       dec_req,
  input  logic       new_req,
  input  logic [9:0] new_offset,
  input  logic       ais_force,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic [9:0] cur_offset,
  output logic       pos_stuff,
  output logic       neg_stuff,
  output logic       req_ack,
  output logic       req_rej
);

  localparam logic [9:0] MAXOFFSET = 10'd139;
  localparam logic [1:0] GUARD     = 2'd3;
  localparam logic [3:0] NORM_NDF  = 4'b0110;
  localparam logic [3:0] EN_NDF    = 4'b1001;
  localparam logic [9:0] INV_I     = 10'b1010101010;
  localparam logic [9:0] INV_D     = 10'b0101010101;
  localparam logic [7:0] AIS_BYTE  = 8'hFF;

  typedef enum logic [1:0] {
    MODE_NORM = 2'd0,
    MODE_AIS  = 2'd1,
    MODE_INC  = 2'd2,
    MODE_DEC  = 2'd3
  } mode_t;

  mode_t      mode_q, mode_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] guard_q, guard_d;
  logic       pend_inc_q, pend_inc_d;
  logic       pend_dec_q, pend_dec_d;
  logic       pend_new_q, pend_new_d;
  logic [9:0] new_off_q, new_off_d;
  logic       restore_q, restore_d;
  logic [9:0] off_q, off_d;
  logic [7:0] v2_q, v2_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_vld_q, dout_vld_d;
  logic       pos_q, pos_d;
  logic       neg_q, neg_d;
  logic       ack_q, ack_d;
  logic       rej_q, rej_d;

  logic [1:0] cur_idx;
  logic [9:0] ptr;
  logic [3:0] ndf;
  logic       clr_inc, clr_dec, clr_new;

  // State register with asynchronous active-low reset; restore flag set
  // so the first multiframe after reset carries EN_NDF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_NORM;
      idx_q      <= 2'd0;
      guard_q    <= 2'd0;
      pend_inc_q <= 1'b0;
      pend_dec_q <= 1'b0;
      pend_new_q <= 1'b0;
      new_off_q  <= 10'd0;
      restore_q  <= 1'b1;
      off_q      <= 10'd0;
      v2_q       <= 8'h00;
      dout_q     <= 8'h00;
      dout_vld_q <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      ack_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      guard_q    <= guard_d;
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      pend_new_q <= pend_new_d;
      new_off_q  <= new_off_d;
      restore_q  <= restore_d;
      off_q      <= off_d;
      v2_q       <= v2_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      ack_q      <= ack_d;
      rej_q      <= rej_d;
    end
  end

  // Byte sequencing, commit decision at V1 and request bookkeeping.
  always_comb begin
    mode_d     = mode_q;
    idx_d      = idx_q;
    guard_d    = guard_q;
    new_off_d  = new_off_q;
    restore_d  = restore_q;
    off_d      = off_q;
    v2_d       = v2_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    pos_d      = pos_q;
    neg_d      = neg_q;
    ack_d      = 1'b0;
    rej_d      = 1'b0;
    cur_idx    = txsof ? 2'd0 : idx_q;
    ptr        = off_q;
    ndf        = NORM_NDF;
    clr_inc    = 1'b0;
    clr_dec    = 1'b0;
    clr_new    = 1'b0;

    if (ven) begin
      idx_d      = cur_idx + 2'd1;
      dout_vld_d = 1'b1;
      case (cur_idx)
        2'd0: begin
          guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
          pos_d   = 1'b0;
          neg_d   = 1'b0;
          if (ais_force) begin
            // Pending requests survive AIS; pointer is re-announced after.
            mode_d    = MODE_AIS;
            restore_d = 1'b1;
            dout_d    = AIS_BYTE;
            v2_d      = AIS_BYTE;
          end else begin
            mode_d = MODE_NORM;
            if (pend_new_q) begin
              clr_new = 1'b1;
              if (new_off_q <= MAXOFFSET) begin
                off_d     = new_off_q;
                ptr       = new_off_q;
                ndf       = EN_NDF;
                ack_d     = 1'b1;
                guard_d   = GUARD;
                restore_d = 1'b0;
              end else begin
                rej_d = 1'b1;
              end
            end else if (restore_q) begin
              ndf       = EN_NDF;
              guard_d   = GUARD;
              restore_d = 1'b0;
            end else if ((guard_q == 2'd0) && (pend_inc_q || pend_dec_q)) begin
              clr_inc = 1'b1;
              clr_dec = 1'b1;
              if (pend_inc_q && pend_dec_q) begin
                rej_d = 1'b1;
              end else if (pend_inc_q) begin
                mode_d  = MODE_INC;
                ptr     = off_q ^ INV_I;
                pos_d   = 1'b1;
                ack_d   = 1'b1;
                guard_d = GUARD;
              end else begin
                mode_d  = MODE_DEC;
                ptr     = off_q ^ INV_D;
                neg_d   = 1'b1;
                ack_d   = 1'b1;
                guard_d = GUARD;
              end
            end
            dout_d = {ndf, 2'b10, ptr[9:8]};
            v2_d   = ptr[7:0];
          end
        end
        2'd1: begin
          dout_d = v2_q;
        end
        2'd2: begin
          dout_d = (mode_q == MODE_AIS) ? AIS_BYTE : 8'h00;
        end
        default: begin
          dout_d = (mode_q == MODE_AIS) ? AIS_BYTE : 8'h00;
          pos_d  = 1'b0;
          neg_d  = 1'b0;
          if (mode_q == MODE_INC) begin
            off_d = (off_q == MAXOFFSET) ? 10'd0 : off_q + 10'd1;
          end else if (mode_q == MODE_DEC) begin
            off_d = (off_q == 10'd0) ? MAXOFFSET : off_q - 10'd1;
          end
        end
      endcase
    end else if (txsof) begin
      idx_d = 2'd0;
    end

    // A pulse coinciding with a commit is kept for the next commit.
    pend_inc_d = (pend_inc_q & ~clr_inc) | inc_req;
    pend_dec_d = (pend_dec_q & ~clr_dec) | dec_req;
    pend_new_d = (pend_new_q & ~clr_new) | new_req;
    if (new_req) begin
      new_off_d = new_offset;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign cur_offset = off_q;
  assign pos_stuff  = pos_q;
  assign neg_stuff  = neg_q;
  assign req_ack    = ack_q;
  assign req_rej    = rej_q;

endmodule

// File: tb/tb_ptr_gen.sv
// tb_ptr_gen: directed stimulus with a byte scoreboard for ptr_gen.
module tb_ptr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txsof = 1'b0;
  logic       ven = 1'b0;
  logic       inc_req = 1'b0;
  logic       dec_req = 1'b0;
  logic       new_req = 1'b0;
  logic [9:0] new_offset = 10'd0;
  logic       ais_force = 1'b0;
  logic [7:0] dout;
  logic       dout_vld;
  logic [9:0] cur_offset;
  logic       pos_stuff;
  logic       neg_stuff;
  logic       req_ack;
  logic       req_rej;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       ack;
    logic       rej;
    logic       pos;
    logic       neg;
    logic       chk_st;
  } exp_t;

  exp_t sb[$];

  ptr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .txsof      (txsof),
    .ven        (ven),
    .inc_req    (inc_req),
    .dec_req    (dec_req),
    .new_req    (new_req),
    .new_offset (new_offset),
    .ais_force  (ais_force),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .cur_offset (cur_offset),
    .pos_stuff  (pos_stuff),
    .neg_stuff  (neg_stuff),
    .req_ack    (req_ack),
    .req_rej    (req_rej)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry per presented byte.
  always @(negedge clk) begin
    exp_t e;
    if (dout_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", {24'd0, dout}, 32'hDEAD);
      end else begin
        e = sb.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e.d});
        check("req_ack", {31'd0, req_ack}, {31'd0, e.ack});
        check("req_rej", {31'd0, req_rej}, {31'd0, e.rej});
        if (e.chk_st) begin
          check("pos_stuff", {31'd0, pos_stuff}, {31'd0, e.pos});
          check("neg_stuff", {31'd0, neg_stuff}, {31'd0, e.neg});
        end
      end
    end
  end

  task automatic ven_x(input logic sof, input logic [7:0] d, input logic ack,
                       input logic rej, input logic pos, input logic neg,
                       input logic chk);
    exp_t e;
    e = '{d: d, ack: ack, rej: rej, pos: pos, neg: neg, chk_st: chk};
    sb.push_back(e);
    @(posedge clk); #1 ven = 1'b1; txsof = sof;
    @(posedge clk); #1 ven = 1'b0; txsof = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic mf(input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v34,
                    input logic ack, input logic rej, input logic pos, input logic neg);
    ven_x(1'b1, v1, ack, rej, pos, neg, 1'b1);
    ven_x(1'b0, v2, 1'b0, 1'b0, pos, neg, 1'b1);
    ven_x(1'b0, v34, 1'b0, 1'b0, pos, neg, 1'b1);
    ven_x(1'b0, v34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_new(input logic [9:0] off);
    @(posedge clk); #1 new_req = 1'b1; new_offset = off;
    @(posedge clk); #1 new_req = 1'b0;
  endtask

  task automatic pulse_incdec(input logic i, input logic d);
    @(posedge clk); #1 inc_req = i; dec_req = d;
    @(posedge clk); #1 inc_req = 1'b0; dec_req = 1'b0;
  endtask

  task automatic check_rst_outputs();
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_vld", {31'd0, dout_vld}, 32'd0);
    check("rst_offset", {22'd0, cur_offset}, 32'd0);
    check("rst_pos", {31'd0, pos_stuff}, 32'd0);
    check("rst_neg", {31'd0, neg_stuff}, 32'd0);
    check("rst_ack", {31'd0, req_ack}, 32'd0);
    check("rst_rej", {31'd0, req_rej}, 32'd0);
  endtask

  initial begin
    #2;
    check_rst_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // First multiframe after reset restores, second is normal.
    mf(8'h98, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    mf(8'h68, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // New pointer values.
    pulse_new(10'd105);
    mf(8'h98, 8'h69, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("offset_105", {22'd0, cur_offset}, 32'd105);
    pulse_new(10'd139);
    mf(8'h98, 8'h8B, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("offset_139", {22'd0, cur_offset}, 32'd139);

    // Increment held by the guard for three multiframes, then sent.
    pulse_incdec(1'b1, 1'b0);
    repeat (3) mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    mf(8'h6A, 8'h21, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("offset_wrap_0", {22'd0, cur_offset}, 32'd0);

    // Decrement right after the increment.
    pulse_incdec(1'b0, 1'b1);
    repeat (3) mf(8'h68, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    mf(8'h69, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("offset_wrap_139", {22'd0, cur_offset}, 32'd139);
    mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // AIS for two multiframes, then restore with EN_NDF.
    ais_force = 1'b1;
    repeat (2) mf(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    ais_force = 1'b0;
    mf(8'h98, 8'h8B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("offset_after_ais", {22'd0, cur_offset}, 32'd139);

    // Out-of-range new pointer is rejected.
    pulse_new(10'd200);
    mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("offset_after_rej", {22'd0, cur_offset}, 32'd139);

    // Simultaneous inc and dec: rejected once guard expires.
    pulse_incdec(1'b1, 1'b1);
    repeat (2) mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    mf(8'h68, 8'h8B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // ais_force raised mid-multiframe has no effect until next V1.
    ven_x(1'b1, 8'h68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ais_force = 1'b1;
    ven_x(1'b0, 8'h8B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ais_force = 1'b0;

    // Reset mid-multiframe clears everything; next V1 restores offset 0.
    ven_x(1'b1, 8'h68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h8B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #3 rst = 1'b0;
    #1 check("midrst_offset", {22'd0, cur_offset}, 32'd0);
    check_rst_outputs();
    @(posedge clk); #1 rst = 1'b1;
    mf(8'h98, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // txsof alone re-aligns the index; the following ven is V1.
    ven_x(1'b1, 8'h68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 txsof = 1'b1;
    @(posedge clk); #1 txsof = 1'b0;
    ven_x(1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ven_x(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
